// File: rtl/clk_en_gen_if.sv
// Configuration bus for clk_en_gen: valid/ready write channel plus an error pulse.
// The cfg_phase field exists only when CLK_EN_GEN_PHASE_EN is defined.
interface clk_en_gen_if #(
  parameter int NUM_CH = 2,
  parameter int ACC_W  = 24
) ();
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [ACC_W-1:0] cfg_inc;
`ifdef CLK_EN_GEN_PHASE_EN
  logic [ACC_W-1:0] cfg_phase;
`endif
  logic             cfg_err;

`ifdef CLK_EN_GEN_PHASE_EN
  modport master (output cfg_valid, cfg_ch, cfg_inc, cfg_phase, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_ch, cfg_inc, cfg_phase, output cfg_ready, cfg_err);
`else
  modport master (output cfg_valid, cfg_ch, cfg_inc, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_ch, cfg_inc, output cfg_ready, cfg_err);
`endif
endinterface

// File: rtl/clk_en_gen.sv
// NUM_CH phase-accumulator clock-enable generator with settle/lock sequencing.
// Optional per-channel start phase: define CLK_EN_GEN_PHASE_EN.
module clk_en_gen #(
  parameter int NUM_CH      = 2,
  parameter int ACC_W       = 24,
  parameter int LOCK_CYCLES = 5
) (
  input  logic              clk_in1,
  input  logic              reset_n,
  clk_en_gen_if.slave       cfg,
  output logic              locked,
  output logic [NUM_CH-1:0] en_out,
  output logic [NUM_CH-1:0] clk_out
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOCKED, ST_LOAD} state_t;

  state_t         state_q, state_d;
  logic [15:0]    lock_cnt_q, lock_cnt_d;
  logic           cfg_err_q;

  logic [CH_W-1:0] ch_sel;
  logic [CH_W:0]   ch_ext;
  logic            wr_acc, ch_ok, wr_load, wr_bad, lock_done;

  logic [ACC_W-1:0] inc_q [NUM_CH];
  logic [ACC_W-1:0] acc_q [NUM_CH];
  logic [ACC_W:0]   sum_p0 [NUM_CH];
`ifdef CLK_EN_GEN_PHASE_EN
  logic [ACC_W-1:0] phase_q [NUM_CH];
`endif

  function automatic logic [ACC_W:0] acc_step(input logic [ACC_W-1:0] a,
                                              input logic [ACC_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign ch_sel        = cfg.cfg_ch;
  assign ch_ext        = {1'b0, ch_sel};
  assign cfg.cfg_ready = (state_q != ST_LOAD);
  assign cfg.cfg_err   = cfg_err_q;

  assign wr_acc    = cfg.cfg_valid & cfg.cfg_ready;
  assign ch_ok     = (ch_ext < (CH_W+1)'(NUM_CH));
  assign wr_load   = wr_acc & ch_ok;
  assign wr_bad    = wr_acc & ~ch_ok;
  assign lock_done = (state_q == ST_IDLE) && (lock_cnt_q == 16'(LOCK_CYCLES - 1));

  // Control: a valid write always wins over lock completion on the same edge.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_load) begin
          state_d    = ST_LOAD;
          lock_cnt_d = '0;
        end else if (lock_done) begin
          state_d    = ST_LOCKED;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 16'd1;
        end
      end
      ST_LOCKED: begin
        if (wr_load) begin
          state_d    = ST_LOAD;
          lock_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        state_d    = ST_IDLE;
        lock_cnt_d = '0;
      end
      default: begin
        state_d    = ST_IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in1 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      lock_cnt_q <= '0;
      locked     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      locked     <= (state_d == ST_LOCKED);
      cfg_err_q  <= wr_bad;
    end
  end

  // Stage p0: next accumulator value with carry for every channel.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      sum_p0[c] = acc_step(acc_q[c], inc_q[c]);
    end
  end

  // Stage p1: registered enables; accumulators re-seed on every accepted load.
  always_ff @(posedge clk_in1 or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        inc_q[c] <= '0;
        acc_q[c] <= '0;
`ifdef CLK_EN_GEN_PHASE_EN
        phase_q[c] <= '0;
`endif
      end
      en_out  <= '0;
      clk_out <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        en_out[c] <= 1'b0;
        if (wr_load) begin
          if (ch_ext == (CH_W+1)'(c)) begin
            inc_q[c] <= cfg.cfg_inc;
`ifdef CLK_EN_GEN_PHASE_EN
            phase_q[c] <= cfg.cfg_phase;
            acc_q[c]   <= cfg.cfg_phase;
          end else begin
            acc_q[c]   <= phase_q[c];
`else
          end
          begin
            acc_q[c] <= '0;
`endif
          end
        end else if (state_q == ST_LOCKED) begin
          acc_q[c]   <= sum_p0[c][ACC_W-1:0];
          en_out[c]  <= sum_p0[c][ACC_W];
          clk_out[c] <= clk_out[c] ^ sum_p0[c][ACC_W];
        end
      end
    end
  end
endmodule
